// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment patterns {a..g}, special BCD codes and
// the capture FSM state type. Also used by the seven_segment_decoder.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_BLANK   = 4'hA;
    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic {
        SETTLE = 1'b0,
        HOLD   = 1'b1
    } cap_state_t;

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern -> {err, nibble}. Unlisted patterns give 4'hF/err.
// BLANK_DETECT_EN: when defined, the all-off pattern is a legal blank digit (4'hA).
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       err
);

    always_comb begin
        nibble = BCD_INVALID;
        err    = 1'b1;
        case (seg)
            SEG_0:     begin nibble = 4'd0; err = 1'b0; end
            SEG_1:     begin nibble = 4'd1; err = 1'b0; end
            SEG_2:     begin nibble = 4'd2; err = 1'b0; end
            SEG_3:     begin nibble = 4'd3; err = 1'b0; end
            SEG_4:     begin nibble = 4'd4; err = 1'b0; end
            SEG_5:     begin nibble = 4'd5; err = 1'b0; end
            SEG_6:     begin nibble = 4'd6; err = 1'b0; end
            SEG_7:     begin nibble = 4'd7; err = 1'b0; end
            SEG_8:     begin nibble = 4'd8; err = 1'b0; end
            SEG_9:     begin nibble = 4'd9; err = 1'b0; end
`ifdef BLANK_DETECT_EN
            SEG_BLANK: begin nibble = BCD_BLANK; err = 1'b0; end
`endif
            default:   ;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Recovers BCD digits from a multiplexed 7-segment bus: input register, stability
// filter, capture FSM and frame assembly. Blank handling follows BLANK_DETECT_EN.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid,
    output logic                    sel_err
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]              smp_seg, prv_seg;
    logic [NUM_DIGITS-1:0]   smp_sel, prv_sel;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    cap_state_t              state_q, state_d;
    logic                    same, capture, sel_ok, cap_ok, complete, pend_q;
    logic [NUM_DIGITS-1:0]   seen_q, seen_base, seen_d;
    logic [4*NUM_DIGITS-1:0] shadow_bcd;
    logic [NUM_DIGITS-1:0]   shadow_err;
    logic [3:0]              dec_nib;
    logic                    dec_err;

    seg7_pattern_decode u_decode (
        .seg    (smp_seg),
        .nibble (dec_nib),
        .err    (dec_err)
    );

    always_comb begin
        same    = (smp_seg == prv_seg) && (smp_sel == prv_sel);
        cnt_d   = '0;
        state_d = state_q;
        capture = 1'b0;
        if (same) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
        if (!same) begin
            state_d = SETTLE;
        end else if (state_q == SETTLE && cnt_d == CNT_CAP) begin
            capture = 1'b1;
            state_d = HOLD;
        end
        sel_ok    = is_onehot(32'(smp_sel));
        cap_ok    = capture && sel_ok;
        // A pending frame clears the mask this edge; a coincident capture opens the next frame.
        seen_base = pend_q ? '0 : seen_q;
        seen_d    = cap_ok ? (seen_base | smp_sel) : seen_base;
        complete  = cap_ok && (seen_d == '1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= SETTLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smp_seg     <= '0;
            prv_seg     <= '0;
            smp_sel     <= '0;
            prv_sel     <= '0;
            cnt_q       <= '0;
            seen_q      <= '0;
            pend_q      <= 1'b0;
            shadow_bcd  <= '0;
            shadow_err  <= '0;
            bcd_out     <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            smp_seg     <= seg_in;
            smp_sel     <= dig_sel;
            prv_seg     <= smp_seg;
            prv_sel     <= smp_sel;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            pend_q      <= complete;
            frame_valid <= pend_q;
            sel_err     <= capture && !sel_ok;
            if (pend_q) begin
                bcd_out   <= shadow_bcd;
                digit_err <= shadow_err;
            end
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (cap_ok && smp_sel[i]) begin
                    shadow_bcd[4*i +: 4] <= dec_nib;
                    shadow_err[i]        <= dec_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture (NUM_DIGITS=4, STABLE_CYCLES=4); honours BLANK_DETECT_EN.
module tb_seg7_scan_capture;

    localparam logic [6:0] SEGTAB [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };
    localparam logic [3:0] D0 = 4'b0001, D1 = 4'b0010, D2 = 4'b0100, D3 = 4'b1000;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic [15:0] bcd_out;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        sel_err;

    int tests = 0;
    int fails = 0;
    int fv_total, se_total, fv_idx, se_idx;

    seg7_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .bcd_out     (bcd_out),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .sel_err     (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one digit for a number of clock edges; index 0 is the first edge seeing it.
    task automatic scan(input logic [3:0] sel, input logic [6:0] seg, input int cycles);
        @(negedge clk);
        dig_sel = sel;
        seg_in  = seg;
        fv_idx  = -1;
        se_idx  = -1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (frame_valid) begin fv_total++; fv_idx = i; end
            if (sel_err)     begin se_total++; se_idx = i; end
        end
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        seg_in  = SEGTAB[3];
        dig_sel = D0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bcd_out !== 16'h0000) begin fails++; $display("FAIL reset_bcd got %h want 0000", bcd_out); end
        tests++; if (digit_err !== 4'h0) begin fails++; $display("FAIL reset_err got %b want 0000", digit_err); end
        tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset_fv got %b want 0", frame_valid); end
        tests++; if (sel_err !== 1'b0) begin fails++; $display("FAIL reset_selerr got %b want 0", sel_err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_frame;
        fv_total = 0;
        scan(D0, 7'b1111001, 8);
        scan(D1, 7'b1011011, 8);
        scan(D2, 7'b0110000, 8);
        scan(D3, 7'b1111111, 8);
        tests++; if (fv_idx !== 5) begin fails++; $display("FAIL basic_latency got %0d want 5", fv_idx); end
        tests++; if (fv_total !== 1) begin fails++; $display("FAIL basic_fv_count got %0d want 1", fv_total); end
        tests++; if (bcd_out !== 16'h8153) begin fails++; $display("FAIL basic_bcd got %h want 8153", bcd_out); end
        tests++; if (digit_err !== 4'h0) begin fails++; $display("FAIL basic_err got %b want 0000", digit_err); end
    endtask

    task automatic test_decode_table;
        for (int v = 0; v < 10; v++) begin
            fv_total = 0;
            scan(D0, SEGTAB[v], 8);
            scan(D1, SEGTAB[7], 8);
            scan(D2, SEGTAB[4], 8);
            scan(D3, SEGTAB[2], 8);
            tests++;
            if (fv_total !== 1 || bcd_out !== (16'h2470 | 16'(v)) || digit_err !== 4'h0) begin
                fails++;
                $display("FAIL decode_%0d got fv=%0d bcd=%h err=%b want fv=1 bcd=%h err=0000",
                         v, fv_total, bcd_out, digit_err, 16'h2470 | 16'(v));
            end
        end
        fv_total = 0;
        scan(D0, SEGTAB[0], 8);
        scan(D1, SEGTAB[1], 8);
        scan(D2, 7'b1010101, 8);
        scan(D3, SEGTAB[3], 8);
        tests++; if (fv_total !== 1) begin fails++; $display("FAIL invalid_fv got %0d want 1", fv_total); end
        tests++; if (bcd_out !== 16'h3F10) begin fails++; $display("FAIL invalid_bcd got %h want 3f10", bcd_out); end
        tests++; if (digit_err !== 4'b0100) begin fails++; $display("FAIL invalid_err got %b want 0100", digit_err); end
    endtask

    task automatic test_glitch;
        fv_total = 0;
        scan(D0, SEGTAB[1], 8);
        for (int k = 0; k < 6; k++) scan(D1, (k % 2 == 0) ? SEGTAB[2] : SEGTAB[6], 2);
        scan(D2, SEGTAB[3], 8);
        scan(D3, SEGTAB[4], 8);
        tests++; if (fv_total !== 0) begin fails++; $display("FAIL glitch_nocap got fv=%0d want 0", fv_total); end
        scan(D1, SEGTAB[9], 6);
        tests++; if (fv_idx !== 5) begin fails++; $display("FAIL glitch_capture_idx got %0d want 5", fv_idx); end
        tests++; if (fv_total !== 1) begin fails++; $display("FAIL glitch_fv got %0d want 1", fv_total); end
        tests++; if (bcd_out !== 16'h4391) begin fails++; $display("FAIL glitch_bcd got %h want 4391", bcd_out); end
    endtask

    task automatic test_sel_err;
        fv_total = 0;
        se_total = 0;
        scan(D1, SEGTAB[6], 8);
        scan(D3, SEGTAB[8], 8);
        scan(4'b0101, SEGTAB[5], 6);
        tests++; if (se_total !== 1) begin fails++; $display("FAIL selerr_count got %0d want 1", se_total); end
        tests++; if (se_idx !== 4) begin fails++; $display("FAIL selerr_idx got %0d want 4", se_idx); end
        tests++; if (fv_total !== 0) begin fails++; $display("FAIL selerr_nofv got %0d want 0", fv_total); end
        scan(D0, SEGTAB[4], 8);
        scan(D2, SEGTAB[7], 8);
        tests++; if (fv_total !== 1) begin fails++; $display("FAIL selerr_frame_fv got %0d want 1", fv_total); end
        tests++; if (bcd_out !== 16'h8764) begin fails++; $display("FAIL selerr_bcd got %h want 8764", bcd_out); end
        tests++; if (se_total !== 1) begin fails++; $display("FAIL selerr_total got %0d want 1", se_total); end
    endtask

    task automatic test_reset_midframe;
        fv_total = 0;
        scan(D0, SEGTAB[5], 8);
        scan(D1, SEGTAB[6], 8);
        scan(D2, SEGTAB[7], 8);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests++; if (bcd_out !== 16'h0000) begin fails++; $display("FAIL midrst_bcd got %h want 0000", bcd_out); end
        @(negedge clk);
        rst_n = 1'b1;
        scan(D3, SEGTAB[9], 8);
        tests++; if (fv_total !== 0) begin fails++; $display("FAIL midrst_partial got fv=%0d want 0", fv_total); end
        scan(D0, SEGTAB[2], 8);
        scan(D1, SEGTAB[0], 8);
        scan(D2, SEGTAB[8], 8);
        tests++; if (fv_total !== 1) begin fails++; $display("FAIL midrst_fv got %0d want 1", fv_total); end
        tests++; if (bcd_out !== 16'h9802) begin fails++; $display("FAIL midrst_bcd2 got %h want 9802", bcd_out); end
    endtask

    task automatic test_blank;
        logic [15:0] exp_bcd;
        logic [3:0]  exp_err;
`ifdef BLANK_DETECT_EN
        exp_bcd = 16'hA321;
        exp_err = 4'b0000;
`else
        exp_bcd = 16'hF321;
        exp_err = 4'b1000;
`endif
        fv_total = 0;
        scan(D0, SEGTAB[1], 8);
        scan(D1, SEGTAB[2], 8);
        scan(D2, SEGTAB[3], 8);
        scan(D3, 7'b0000000, 8);
        tests++; if (fv_total !== 1) begin fails++; $display("FAIL blank_fv got %0d want 1", fv_total); end
        tests++; if (bcd_out !== exp_bcd) begin fails++; $display("FAIL blank_bcd got %h want %h", bcd_out, exp_bcd); end
        tests++; if (digit_err !== exp_err) begin fails++; $display("FAIL blank_err got %b want %b", digit_err, exp_err); end
    endtask

    initial begin
        fv_total = 0;
        se_total = 0;
        fv_idx   = -1;
        se_idx   = -1;
        test_reset();
        test_basic_frame();
        test_decode_table();
        test_glitch();
        test_sel_err();
        test_reset_midframe();
        test_blank();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
